arbitro_sumador: RTL and testbench
==================================

Name: arbitro_sumador

Overview:
- Shares the single 4-bit `sumador` adder instance between N_REQ independent requesters.
- Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one requester at a time.
- The sum is returned on one result channel, tagged with the requester index, with valid/ready backpressure.
- Sits between operand sources (test/stimulus blocks, JTAG-driven registers) and the shared adder.

Parameters:
- N_REQ, 4, number of requesters (2..8). Index width ID_W = $clog2(N_REQ), minimum 1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  requester i has operands pending
- req_ready  output  N_REQ  one-hot grant/accept; handshake on valid&ready
- req_a  input  N_REQ*4  operand a of requester i, bits [4i+3:4i]
- req_b  input  N_REQ*4  operand b of requester i, bits [4i+3:4i]
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_suma  output  5  a+b, bit 4 = carry
- res_id  output  ID_W  index of the requester that owns res_suma
- ocupado  output  1  high in any state other than INACTIVO
- cont_ops  output  8  completed-result counter, wraps at 255->0

Behaviour:
- FSM states (package enum): INACTIVO, SUMA, ENTREGA.
- INACTIVO:
  - If any req_valid is high, choose winner = first i with req_valid[i], searching ptr, ptr+1, ... mod N_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - At the clock edge: capture req_a/req_b of winner into a_reg/b_reg and winner into id_reg; set ptr <= (winner==N_REQ-1) ? 0 : winner+1; go to SUMA.
  - If no req_valid is high, stay in INACTIVO and leave ptr unchanged.
- SUMA:
  - a_reg/b_reg drive the sumador instance.
  - At the edge: res_suma_reg <= sumador output, res_id <= id_reg; go to ENTREGA.
  - req_ready is all 0.
- ENTREGA:
  - res_valid=1. res_suma and res_id are held stable until handshake.
  - On res_valid&res_ready: cont_ops <= cont_ops+1; go to INACTIVO.
  - req_ready is all 0. A new grant is never issued in the same cycle as result acceptance.
- Latency and throughput:
  - Request handshake at edge T -> res_valid high after edge T+1, i.e. visible in cycle T+2.
  - Minimum 3 cycles per operation.
- req_ready depends on req_valid and state only, never on res_ready. Requesters must not make req_valid depend on req_ready.
- A requester dropping req_valid before its handshake has no effect and leaves no state behind.
- Operand changes after the handshake edge do not affect the captured sum.
- Arithmetic: zero-extend both operands to 5 bits. No overflow is possible (max 15+15=30).
- Reset values (asynchronous, immediate on rst_n low):
  - state=INACTIVO, ptr=0, a_reg=b_reg=0, id_reg=0.
  - res_valid=0, res_suma=0, res_id=0, ocupado=0, cont_ops=0.
  - req_ready=0 while rst_n is low.
- Reset mid-operation: any captured or pending result is discarded and not delivered. After release, arbitration restarts from ptr=0.
- Simultaneous requests: strict round-robin. A continuously requesting input is granted at least once every N_REQ grants.

Decomposition:
- Package pkg_sumador:
  - typedef enum estado_arb_t {INACTIVO, SUMA, ENTREGA}
  - localparam ANCHO_OP=4
  - localparam ANCHO_SUMA=5
  - localparam ANCHO_CONT=8
- Sub-module selector_rr: purely combinational round-robin picker.
  - Inputs: valid vector and ptr.
  - Outputs: one-hot grant, encoded winner, any_valid.
- The arbitro_sumador top holds the FSM, registers, counter and the existing sumador instance.

Test Plan:
- Single request: requester 0 sends a=5, b=3, res_ready=1 -> req_ready[0] high in the valid cycle; res_valid 2 cycles after handshake with res_suma=8, res_id=0; cont_ops=1.
- Carry: requester 2 sends 15+1 -> res_suma=16 (5'b10000). Then 9+6 -> 15. Then 0+0 -> 0.
- Round robin: all 4 requesters hold valid with a=i, b=1, res_ready=1 -> grant order 0,1,2,3,0; res_id follows the same order; one grant per 3 cycles.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_suma/res_id stable, req_ready all 0, cont_ops unchanged; accepted on the first cycle res_ready=1.
- Reset mid-operation: assert rst_n=0 while in SUMA -> res_valid never asserts for that request, all outputs 0 at once; after release, requesters 1 and 3 both valid -> requester 1 granted first (ptr=0).
- Counter wrap: complete 256 operations -> cont_ops returns to 0.

Source files
------------

// File: rtl/arbitro_sumador_pkg.sv
// pkg_sumador: shared types and widths for the adder arbiter slice
package pkg_sumador;
    typedef enum logic [1:0] {INACTIVO, SUMA, ENTREGA} estado_arb_t;
    localparam int ANCHO_OP   = 4;
    localparam int ANCHO_SUMA = 5;
    localparam int ANCHO_CONT = 8;
endpackage

// File: rtl/arbitro_sumador_if.sv
// arbitro_sumador_if: requester operand channels plus tagged result channel
interface arbitro_sumador_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    import pkg_sumador::*;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*ANCHO_OP-1:0] req_a;
    logic [N_REQ*ANCHO_OP-1:0] req_b;
    logic                      res_valid;
    logic                      res_ready;
    logic [ANCHO_SUMA-1:0]     res_suma;
    logic [ID_W-1:0]           res_id;
    logic                      ocupado;
    logic [ANCHO_CONT-1:0]     cont_ops;
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_suma, res_id, ocupado, cont_ops
    );
    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_suma, res_id, ocupado, cont_ops
    );
endinterface

// File: rtl/arbitro_sumador_selector_rr.sv
// selector_rr: combinational round-robin picker, search starts at ptr
module selector_rr #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  winner,
    output logic             any_valid
);
    logic [ID_W-1:0] cand;
    always_comb begin
        grant     = '0;
        winner    = '0;
        cand      = '0;
        any_valid = |valid;
        // walk from farthest to nearest so the nearest valid index wins
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (valid[cand]) winner = cand;
        end
        grant[winner] = any_valid;
    end
endmodule

// File: rtl/sumador.sv
// sumador: 4-bit adder with carry out as bit 4
module sumador
    import pkg_sumador::*;
(
    input  logic [ANCHO_OP-1:0]   a,
    input  logic [ANCHO_OP-1:0]   b,
    output logic [ANCHO_SUMA-1:0] suma
);
    assign suma = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/arbitro_sumador.sv
// arbitro_sumador: round-robin sharing of one sumador among N_REQ requesters
module arbitro_sumador
    import pkg_sumador::*;
#(
    parameter int N_REQ = 4
) (
    input logic clk,
    input logic rst_n,
    arbitro_sumador_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    estado_arb_t           estado, estado_sig;
    logic [ID_W-1:0]       ptr, id_reg, res_id_reg, winner;
    logic [ANCHO_OP-1:0]   a_reg, b_reg;
    logic [ANCHO_SUMA-1:0] suma, suma_reg;
    logic [ANCHO_CONT-1:0] cont;
    logic [N_REQ-1:0]      grant;
    logic                  any_valid, toma, entrega;
    selector_rr #(.N_REQ(N_REQ), .ID_W(ID_W)) u_sel (
        .valid(bus.req_valid), .ptr(ptr), .grant(grant), .winner(winner), .any_valid(any_valid)
    );
    sumador u_sumador (.a(a_reg), .b(b_reg), .suma(suma));
    assign toma          = (estado == INACTIVO) && any_valid;
    assign entrega       = (estado == ENTREGA) && bus.res_ready;
    // rst_n gating keeps grants silent while reset is held
    assign bus.req_ready = (estado == INACTIVO && rst_n) ? grant : '0;
    assign bus.res_valid = (estado == ENTREGA);
    assign bus.ocupado   = (estado != INACTIVO);
    assign bus.res_suma  = suma_reg;
    assign bus.res_id    = res_id_reg;
    assign bus.cont_ops  = cont;
    always_comb begin
        estado_sig = estado;
        estado_sig = toma ? SUMA : (estado == SUMA) ? ENTREGA : entrega ? INACTIVO : estado;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= INACTIVO;
            ptr        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            id_reg     <= '0;
            suma_reg   <= '0;
            res_id_reg <= '0;
            cont       <= '0;
        end else begin
            estado <= estado_sig;
            if (toma) begin
                a_reg  <= bus.req_a[ANCHO_OP*int'(winner) +: ANCHO_OP];
                b_reg  <= bus.req_b[ANCHO_OP*int'(winner) +: ANCHO_OP];
                id_reg <= winner;
                ptr    <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            end
            if (estado == SUMA) begin
                suma_reg   <= suma;
                res_id_reg <= id_reg;
            end
            if (entrega) cont <= cont + 1'b1;
        end
    end
endmodule

// File: tb/tb_arbitro_sumador.sv
// tb_arbitro_sumador: directed vector table plus multi-cycle corner sequences
module tb_arbitro_sumador;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    always #5 clk = ~clk;
    arbitro_sumador_if #(.N_REQ(4)) bus ();
    arbitro_sumador #(.N_REQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] s;
    } vec_t;
    vec_t tv [7];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        bus.req_a[4*i +: 4] = a;
        bus.req_b[4*i +: 4] = b;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        exp_cnt = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask
    task automatic op_single(input int i, input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
        set_op(i, a, b);
        bus.req_valid = 4'(1 << i);
        #1 chk("grant", bus.req_ready, 32'(1 << i));
        tick();
        bus.req_valid = '0;
        set_op(i, ~a, ~b);
        #1 chk("ready_suma", bus.req_ready, 0);
        chk("ocupado_suma", bus.ocupado, 1);
        chk("valid_suma", bus.res_valid, 0);
        tick();
        chk("res_valid", bus.res_valid, 1);
        chk("res_suma", bus.res_suma, s);
        chk("res_id", bus.res_id, i);
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        chk("cont_ops", bus.cont_ops, exp_cnt);
        chk("res_valid_off", bus.res_valid, 0);
        chk("ocupado_off", bus.ocupado, 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        tv[0] = '{0, 4'd5, 4'd3, 5'd8};
        tv[1] = '{2, 4'd15, 4'd1, 5'd16};
        tv[2] = '{2, 4'd9, 4'd6, 5'd15};
        tv[3] = '{2, 4'd0, 4'd0, 5'd0};
        tv[4] = '{1, 4'd15, 4'd15, 5'd30};
        tv[5] = '{3, 4'd7, 4'd8, 5'd15};
        tv[6] = '{1, 4'd10, 4'd3, 5'd13};
        bus.req_valid = '1;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.res_ready = 1'b1;
        #3;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_ocupado", bus.ocupado, 0);
        chk("rst_suma", bus.res_suma, 0);
        chk("rst_id", bus.res_id, 0);
        chk("rst_cont", bus.cont_ops, 0);
        bus.req_valid = '0;
        tick();
        do_reset();
        foreach (tv[k]) op_single(tv[k].id, tv[k].a, tv[k].b, tv[k].s);
        // round robin with all requesters holding valid
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 4'(i), 4'd1);
        bus.req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            #1 chk("rr_grant", bus.req_ready, 32'(1 << (g % 4)));
            tick();
            chk("rr_no_grant", bus.req_ready, 0);
            tick();
            chk("rr_valid", bus.res_valid, 1);
            chk("rr_id", bus.res_id, g % 4);
            chk("rr_suma", bus.res_suma, (g % 4) + 1);
            tick();
            exp_cnt++;
        end
        chk("rr_cont", bus.cont_ops, exp_cnt);
        bus.req_valid = '0;
        // backpressure: ptr is now 1 after the fifth grant went to 0
        bus.res_ready = 1'b0;
        set_op(1, 4'd4, 4'd9);
        bus.req_valid = 4'b0010;
        #1 chk("bp_grant", bus.req_ready, 2);
        tick();
        bus.req_valid = '1;
        set_op(1, 4'd0, 4'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_suma", bus.res_suma, 13);
            chk("bp_id", bus.res_id, 1);
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_cont", bus.cont_ops, exp_cnt);
            tick();
        end
        bus.res_ready = 1'b1;
        #1 chk("bp_still_valid", bus.res_valid, 1);
        chk("bp_no_grant_accept", bus.req_ready, 0);
        tick();
        exp_cnt++;
        chk("bp_cont_inc", bus.cont_ops, exp_cnt);
        chk("bp_released", bus.res_valid, 0);
        chk("bp_next_grant", bus.req_ready, 4);
        bus.req_valid = 4'b0100;
        set_op(2, 4'd3, 4'd4);
        tick();
        // reset while the captured request sits in SUMA
        chk("mid_ocupado", bus.ocupado, 1);
        rst_n = 1'b0;
        exp_cnt = 0;
        #1 chk("mid_valid", bus.res_valid, 0);
        chk("mid_ocupado0", bus.ocupado, 0);
        chk("mid_cont", bus.cont_ops, 0);
        chk("mid_suma", bus.res_suma, 0);
        chk("mid_id", bus.res_id, 0);
        chk("mid_ready", bus.req_ready, 0);
        tick();
        bus.req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_no_result", bus.res_valid, 0);
        set_op(1, 4'd6, 4'd2);
        set_op(3, 4'd1, 4'd1);
        bus.req_valid = 4'b1010;
        #1 chk("mid_grant1", bus.req_ready, 2);
        tick();
        tick();
        chk("mid_id1", bus.res_id, 1);
        chk("mid_suma1", bus.res_suma, 8);
        tick();
        #1 chk("mid_grant3", bus.req_ready, 8);
        tick();
        bus.req_valid = '0;
        tick();
        chk("mid_id3", bus.res_id, 3);
        chk("mid_suma3", bus.res_suma, 2);
        tick();
        chk("mid_cont2", bus.cont_ops, 2);
        // counter wrap over 256 back-to-back operations
        do_reset();
        set_op(0, 4'd1, 4'd1);
        bus.req_valid = 4'b0001;
        repeat (765) tick();
        chk("wrap_255", bus.cont_ops, 255);
        repeat (3) tick();
        chk("wrap_0", bus.cont_ops, 0);
        bus.req_valid = '0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
